eth_rx_stats_collector: RTL and testbench

//  Consumes the 8-bit RX AXI-Stream and error strobes produced by the 1G MAC wrapper, in the
//  MAC rx_clk domain. Counts bytes, good/bad frames, FCS errors, runts and oversize frames
//  per port, gated by an enable that acts only on frame boundaries. Presents a holdable

---
 rtl/eth_rx_stats_collector_pkg.sv | 14 +
 rtl/eth_rx_stats_collector_counter.sv | 27 ++
 rtl/eth_rx_stats_collector.sv | 125 ++++++++++++
 tb/tb_eth_rx_stats_collector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_stats_collector_pkg.sv
// Shared definitions for the RX statistics collector: FSM states and default frame limits.
package eth_rx_stats_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SKIP  = 2'd2
  } rx_state_e;

  localparam int unsigned DEF_MIN_FRAME_LEN = 64;
  localparam int unsigned DEF_MAX_FRAME_LEN = 1522;
  localparam int unsigned DEF_LEN_WIDTH     = 16;

endpackage

// File: rtl/eth_rx_stats_collector_counter.sv
// Clear-priority incrementing counter; wraps or saturates at all-ones depending on SATURATE.
module eth_stats_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  logic at_max;

  assign at_max = SATURATE && (&value);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_rx_stats_collector.sv
// Per-port RX statistics: frame FSM, saturating length counter, commit decode and
// holdable snapshot of the byte/frame/error counters.
module eth_rx_stats_collector
  import eth_rx_stats_collector_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int unsigned LEN_WIDTH     = DEF_LEN_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        stats_hold,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  input  logic        rx_error_fcs,
  output logic        in_frame,
  output logic [63:0] total_bytes,
  output logic [63:0] good_frames,
  output logic [63:0] bad_frames,
  output logic [31:0] fcs_errors,
  output logic [31:0] runt_frames,
  output logic [31:0] oversize_frames
);

  rx_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, cur_len;
  logic                 counted_beat, commit, is_runt, is_over;

  logic [63:0] bytes_cnt, good_cnt, bad_cnt;
  logic [31:0] fcs_cnt, runt_cnt, over_cnt;

  // A tlast beat seen in IDLE is a complete 1-byte frame, so commit fires without leaving IDLE.
  always_comb begin
    state_d      = state_q;
    counted_beat = 1'b0;
    commit       = 1'b0;
    if (rx_axis_tvalid) begin
      case (state_q)
        ST_IDLE: begin
          counted_beat = enable;
          if (rx_axis_tlast) begin
            commit = enable;
          end else begin
            state_d = enable ? ST_COUNT : ST_SKIP;
          end
        end
        ST_COUNT: begin
          counted_beat = 1'b1;
          if (rx_axis_tlast) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (rx_axis_tlast) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // cur_len includes the beat on the bus this cycle.
  always_comb begin
    cur_len = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
    is_runt = cur_len < LEN_WIDTH'(MIN_FRAME_LEN);
    is_over = cur_len > LEN_WIDTH'(MAX_FRAME_LEN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      in_frame <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_frame <= (state_d == ST_COUNT);
      if (rx_axis_tvalid) begin
        len_q <= rx_axis_tlast ? '0 : cur_len;
      end
    end
  end

  eth_stats_counter #(.WIDTH(64), .SATURATE(1'b0)) u_bytes (
    .clk(clk), .rst_n(rst_n), .inc(counted_beat), .clear(clear), .value(bytes_cnt)
  );
  eth_stats_counter #(.WIDTH(64), .SATURATE(1'b0)) u_good (
    .clk(clk), .rst_n(rst_n), .inc(commit && !rx_axis_tuser), .clear(clear), .value(good_cnt)
  );
  eth_stats_counter #(.WIDTH(64), .SATURATE(1'b0)) u_bad (
    .clk(clk), .rst_n(rst_n), .inc(commit && rx_axis_tuser), .clear(clear), .value(bad_cnt)
  );
  eth_stats_counter #(.WIDTH(32), .SATURATE(1'b1)) u_fcs (
    .clk(clk), .rst_n(rst_n), .inc(rx_error_fcs && enable), .clear(clear), .value(fcs_cnt)
  );
  eth_stats_counter #(.WIDTH(32), .SATURATE(1'b1)) u_runt (
    .clk(clk), .rst_n(rst_n), .inc(commit && is_runt), .clear(clear), .value(runt_cnt)
  );
  eth_stats_counter #(.WIDTH(32), .SATURATE(1'b1)) u_over (
    .clk(clk), .rst_n(rst_n), .inc(commit && is_over), .clear(clear), .value(over_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_bytes     <= '0;
      good_frames     <= '0;
      bad_frames      <= '0;
      fcs_errors      <= '0;
      runt_frames     <= '0;
      oversize_frames <= '0;
    end else if (!stats_hold) begin
      total_bytes     <= bytes_cnt;
      good_frames     <= good_cnt;
      bad_frames      <= bad_cnt;
      fcs_errors      <= fcs_cnt;
      runt_frames     <= runt_cnt;
      oversize_frames <= over_cnt;
    end
  end

endmodule

// File: tb/tb_eth_rx_stats_collector.sv
// Directed bench for eth_rx_stats_collector with hand-computed expected counter values.
module tb_eth_rx_stats_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        stats_hold = 1'b0;
  logic        rx_axis_tvalid = 1'b0;
  logic        rx_axis_tlast = 1'b0;
  logic        rx_axis_tuser = 1'b0;
  logic        rx_error_fcs = 1'b0;
  logic        in_frame;
  logic [63:0] total_bytes, good_frames, bad_frames;
  logic [31:0] fcs_errors, runt_frames, oversize_frames;

  int total = 0;
  int bad = 0;
  logic in_frame_seen;

  eth_rx_stats_collector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .stats_hold(stats_hold),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser), .rx_error_fcs(rx_error_fcs),
    .in_frame(in_frame), .total_bytes(total_bytes), .good_frames(good_frames),
    .bad_frames(bad_frames), .fcs_errors(fcs_errors), .runt_frames(runt_frames),
    .oversize_frames(oversize_frames)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_axis_tvalid = 1'b0;
    clear = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Drives n back-to-back beats; clear_at < 0 means no clear pulse.
  task automatic send_frame(input int n, input logic tu, input logic en_first,
                            input logic en_rest, input int clear_at);
    for (int i = 0; i < n; i++) begin
      rx_axis_tvalid = 1'b1;
      rx_axis_tlast  = (i == n - 1);
      rx_axis_tuser  = tu;
      enable         = (i == 0) ? en_first : en_rest;
      clear          = (i == clear_at);
      tick(1);
      if (i == 0) in_frame_seen = in_frame;
    end
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++; if (in_frame !== 1'b0) begin $display("FAIL reset_in_frame got=%0b exp=0", in_frame); bad++; end
    total++; if (total_bytes !== 64'd0) begin $display("FAIL reset_bytes got=%0d exp=0", total_bytes); bad++; end
    total++; if (good_frames !== 64'd0 || bad_frames !== 64'd0) begin $display("FAIL reset_frames got=%0d/%0d exp=0/0", good_frames, bad_frames); bad++; end
    total++; if (fcs_errors !== 32'd0 || runt_frames !== 32'd0 || oversize_frames !== 32'd0) begin $display("FAIL reset_err got=%0d/%0d/%0d exp=0/0/0", fcs_errors, runt_frames, oversize_frames); bad++; end
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    total++; if (in_frame_seen !== 1'b1) begin $display("FAIL t1_in_frame got=%0b exp=1", in_frame_seen); bad++; end
    tick(2);
    total++; if (in_frame !== 1'b0) begin $display("FAIL t1_in_frame_end got=%0b exp=0", in_frame); bad++; end
    total++; if (total_bytes !== 64'd64) begin $display("FAIL t1_bytes got=%0d exp=64", total_bytes); bad++; end
    total++; if (good_frames !== 64'd1) begin $display("FAIL t1_good got=%0d exp=1", good_frames); bad++; end
    total++; if (bad_frames !== 64'd0) begin $display("FAIL t1_bad got=%0d exp=0", bad_frames); bad++; end
    total++; if (runt_frames !== 32'd0 || oversize_frames !== 32'd0) begin $display("FAIL t1_len got=%0d/%0d exp=0/0", runt_frames, oversize_frames); bad++; end
  endtask

  task automatic test_runt_oversize();
    do_reset();
    send_frame(60, 1'b1, 1'b1, 1'b1, -1);
    send_frame(1600, 1'b0, 1'b1, 1'b1, -1);
    tick(2);
    total++; if (bad_frames !== 64'd1) begin $display("FAIL t2_bad got=%0d exp=1", bad_frames); bad++; end
    total++; if (good_frames !== 64'd1) begin $display("FAIL t2_good got=%0d exp=1", good_frames); bad++; end
    total++; if (runt_frames !== 32'd1) begin $display("FAIL t2_runt got=%0d exp=1", runt_frames); bad++; end
    total++; if (oversize_frames !== 32'd1) begin $display("FAIL t2_over got=%0d exp=1", oversize_frames); bad++; end
    total++; if (total_bytes !== 64'd1660) begin $display("FAIL t2_bytes got=%0d exp=1660", total_bytes); bad++; end
  endtask

  task automatic test_boundaries();
    do_reset();
    send_frame(63, 1'b0, 1'b1, 1'b1, -1);
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    send_frame(1522, 1'b0, 1'b1, 1'b1, -1);
    send_frame(1523, 1'b0, 1'b1, 1'b1, -1);
    tick(2);
    total++; if (runt_frames !== 32'd1) begin $display("FAIL bnd_runt got=%0d exp=1", runt_frames); bad++; end
    total++; if (oversize_frames !== 32'd1) begin $display("FAIL bnd_over got=%0d exp=1", oversize_frames); bad++; end
    total++; if (good_frames !== 64'd4) begin $display("FAIL bnd_good got=%0d exp=4", good_frames); bad++; end
    total++; if (total_bytes !== 64'd3172) begin $display("FAIL bnd_bytes got=%0d exp=3172", total_bytes); bad++; end
  endtask

  task automatic test_enable();
    do_reset();
    send_frame(100, 1'b0, 1'b0, 1'b1, -1);
    tick(2);
    total++; if (in_frame_seen !== 1'b0) begin $display("FAIL t3_skip_in_frame got=%0b exp=0", in_frame_seen); bad++; end
    total++; if (total_bytes !== 64'd0 || good_frames !== 64'd0) begin $display("FAIL t3_skip got=%0d/%0d exp=0/0", total_bytes, good_frames); bad++; end
    send_frame(100, 1'b0, 1'b1, 1'b0, -1);
    tick(2);
    total++; if (total_bytes !== 64'd100) begin $display("FAIL t3_bytes got=%0d exp=100", total_bytes); bad++; end
    total++; if (good_frames !== 64'd1) begin $display("FAIL t3_good got=%0d exp=1", good_frames); bad++; end
  endtask

  task automatic test_fcs();
    do_reset();
    enable = 1'b1; rx_error_fcs = 1'b1; tick(1);
    enable = 1'b0; tick(1);
    rx_error_fcs = 1'b0; enable = 1'b1; tick(1);
    rx_error_fcs = 1'b1; tick(1);
    rx_error_fcs = 1'b0;
    tick(2);
    total++; if (fcs_errors !== 32'd2) begin $display("FAIL fcs_count got=%0d exp=2", fcs_errors); bad++; end
  endtask

  task automatic test_back_to_back_hold();
    do_reset();
    stats_hold = 1'b1;
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    tick(3);
    total++; if (good_frames !== 64'd0 || total_bytes !== 64'd0) begin $display("FAIL t4_frozen got=%0d/%0d exp=0/0", good_frames, total_bytes); bad++; end
    stats_hold = 1'b0;
    tick(1);
    total++; if (good_frames !== 64'd3) begin $display("FAIL t4_good got=%0d exp=3", good_frames); bad++; end
    total++; if (total_bytes !== 64'd192) begin $display("FAIL t4_bytes got=%0d exp=192", total_bytes); bad++; end
  endtask

  task automatic test_clear();
    do_reset();
    send_frame(64, 1'b0, 1'b1, 1'b1, 63);
    tick(2);
    total++; if (good_frames !== 64'd0 || total_bytes !== 64'd0) begin $display("FAIL t5_clr_last got=%0d/%0d exp=0/0", good_frames, total_bytes); bad++; end
    send_frame(64, 1'b0, 1'b1, 1'b1, 9);
    tick(2);
    total++; if (good_frames !== 64'd1) begin $display("FAIL t5_good got=%0d exp=1", good_frames); bad++; end
    total++; if (total_bytes !== 64'd54) begin $display("FAIL t5_bytes got=%0d exp=54", total_bytes); bad++; end
    total++; if (runt_frames !== 32'd0) begin $display("FAIL t5_runt got=%0d exp=0", runt_frames); bad++; end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    enable = 1'b1; rx_axis_tvalid = 1'b1; rx_axis_tlast = 1'b0;
    tick(20);
    total++; if (in_frame !== 1'b1) begin $display("FAIL t6_pre_in_frame got=%0b exp=1", in_frame); bad++; end
    rst_n = 1'b0;
    tick(1);
    total++; if (in_frame !== 1'b0) begin $display("FAIL t6_rst_in_frame got=%0b exp=0", in_frame); bad++; end
    total++; if (total_bytes !== 64'd0 || good_frames !== 64'd0) begin $display("FAIL t6_rst_out got=%0d/%0d exp=0/0", total_bytes, good_frames); bad++; end
    rx_axis_tvalid = 1'b0; rst_n = 1'b1;
    tick(1);
    send_frame(64, 1'b0, 1'b1, 1'b1, -1);
    tick(2);
    total++; if (good_frames !== 64'd1 || total_bytes !== 64'd64) begin $display("FAIL t6_after got=%0d/%0d exp=1/64", good_frames, total_bytes); bad++; end
    do_reset();
    send_frame(1, 1'b0, 1'b1, 1'b1, -1);
    total++; if (in_frame_seen !== 1'b0) begin $display("FAIL t6_one_in_frame got=%0b exp=0", in_frame_seen); bad++; end
    tick(2);
    total++; if (runt_frames !== 32'd1) begin $display("FAIL t6_one_runt got=%0d exp=1", runt_frames); bad++; end
    total++; if (total_bytes !== 64'd1 || good_frames !== 64'd1) begin $display("FAIL t6_one_bytes got=%0d/%0d exp=1/1", total_bytes, good_frames); bad++; end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_runt_oversize();
    test_boundaries();
    test_enable();
    test_fcs();
    test_back_to_back_hold();
    test_clear();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
